// File: rtl/sound_sample_decimator.sv
// sound_sample_decimator: box-car averages SO1/SO2 over 2^DECIM_LOG2 ticks into a FWFT FIFO with overflow/underrun flags
module sound_sample_decimator #(
  parameter int DECIM_LOG2 = 4,
  parameter int FIFO_LOG2  = 2
) (
  input  logic                 I_CLK,
  input  logic                 I_RESET_L,
  input  logic [19:0]          I_SO1,
  input  logic [19:0]          I_SO2,
  input  logic                 I_SAMPLE_TICK,
  output logic [19:0]          O_SAMPLE_L,
  output logic [19:0]          O_SAMPLE_R,
  output logic                 O_VALID,
  input  logic                 I_READY,
  output logic [FIFO_LOG2:0]   O_FIFO_LEVEL,
  output logic                 O_OVERFLOW,
  output logic                 O_UNDERRUN,
  input  logic                 I_CLR_FLAGS
);
  localparam int AW    = 20 + DECIM_LOG2;
  localparam int LW    = FIFO_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_LOG2;
  logic [AW-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d, sum_l, sum_r;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic [FIFO_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d, unr_q, unr_d;
  logic [39:0]          mem_q [DEPTH];
  logic [39:0]          head, wdata;
  logic                 final_tick, pop, accept, full, valid;
  // accumulate, decide push/pop and compute next pointer, level and flag state
  always_comb begin
    sum_l      = acc_l_q + AW'(I_SO1);
    sum_r      = acc_r_q + AW'(I_SO2);
    wdata      = {20'(sum_l >> DECIM_LOG2), 20'(sum_r >> DECIM_LOG2)};
    final_tick = I_SAMPLE_TICK & (cnt_q == '1);
    acc_l_d    = final_tick ? '0 : I_SAMPLE_TICK ? sum_l : acc_l_q;
    acc_r_d    = final_tick ? '0 : I_SAMPLE_TICK ? sum_r : acc_r_q;
    cnt_d      = I_SAMPLE_TICK ? cnt_q + DECIM_LOG2'(1) : cnt_q;
    valid      = level_q != '0;
    full       = level_q == LW'(DEPTH);
    pop        = valid & I_READY;
    accept     = final_tick & (~full | pop);
    wptr_d     = accept ? wptr_q + FIFO_LOG2'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + FIFO_LOG2'(1) : rptr_q;
    level_d    = level_q + LW'(accept) - LW'(pop);
    ovf_d      = (final_tick & ~accept) | (ovf_q & ~I_CLR_FLAGS);
    unr_d      = (I_READY & ~valid) | (unr_q & ~I_CLR_FLAGS);
    head       = mem_q[rptr_q];
  end
  // state registers; reset drops any partial sum and empties the FIFO
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unr_q   <= unr_d;
    end
  end
  // FIFO storage needs no reset since reads are masked while empty
  always_ff @(posedge I_CLK) begin
    if (accept) mem_q[wptr_q] <= wdata;
  end
  assign O_VALID      = valid;
  assign O_SAMPLE_L   = valid ? head[39:20] : '0;
  assign O_SAMPLE_R   = valid ? head[19:0] : '0;
  assign O_FIFO_LEVEL = level_q;
  assign O_OVERFLOW   = ovf_q;
  assign O_UNDERRUN   = unr_q;
endmodule
